irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning input synchronizer depth per line (>=2).
REQ-002 SHALL have parameter TIMER_LINE, default 7, meaning source index driven by the optional timer.
REQ-003 SHALL have port clock  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port irq_in  in  8  raw asynchronous device interrupt lines.
REQ-006 SHALL have port wr_en  in  1  register write strobe.
REQ-007 SHALL have port addr  in  3  register select for read and write.
REQ-008 SHALL have port wr_data  in  64  write data; only [31:0] used.
REQ-009 SHALL have port rd_data  out  64  combinational read of the addressed register, zero-extended.
REQ-010 SHALL have port interrupt_source  out  8  one-hot active interrupt, wired to the coprocessor cause IP field.

Function
REQ-011 SHALL map registers: 0 PENDING (write-1-to-clear), 1 MASK, 2 EDGE (1 = edge, 0 = level), 3 CLAIM, 4 COUNT, 5 COMPARE; addresses 6-7 read 0, writes ignored.
REQ-012 SHALL pass each irq_in bit through SYNC_STAGES flops before any use; the last stage is s.
REQ-013 SHALL, for EDGE=1 lines, set PENDING[i] on the cycle after s[i] rises 0->1; the bit holds until cleared.
REQ-014 SHALL, for EDGE=0 lines, make PENDING[i] equal s[i] every cycle; W1C writes have no effect.
REQ-015 SHALL let a set event win over a W1C clear or EOI on the same bit in the same cycle.
REQ-016 SHALL implement FSM IDLE/ACTIVE; in IDLE, if any (PENDING & MASK) bit is set, it latches the highest set index as active_id and enters ACTIVE next cycle.
REQ-017 SHALL drive interrupt_source as one-hot(active_id) in ACTIVE and 0 in IDLE, registered, with no combinational path from irq_in.
REQ-018 SHALL read CLAIM as {28'b0, active, active_id} where active = (state == ACTIVE).
REQ-019 SHALL treat a CLAIM write with wr_data[2:0] == active_id in ACTIVE as EOI: clear the edge PENDING bit and return to IDLE next cycle; a mismatched id or a write in IDLE is ignored.
REQ-020 SHALL return to IDLE without clearing PENDING if MASK[active_id] is written to 0 while ACTIVE.
REQ-021 SHALL ensure a level line still asserted after EOI is re-selected no earlier than one cycle after IDLE is entered.
REQ-022 SHALL keep a higher-priority arrival in PENDING while ACTIVE; there is no preemption.
REQ-023 SHALL reach ACTIVE with worst-case latency of SYNC_STAGES+2 cycles from an irq_in edge to interrupt_source.

Reset
REQ-024 SHALL, on reset, clear the sync flops, PENDING, MASK, EDGE, active_id, COUNT and timer pending, set COMPARE to 32'hFFFF_FFFF, and enter IDLE with interrupt_source = 0.
REQ-025 SHALL let reset override every write or event in the same cycle; reset mid-ACTIVE abandons the service.

Configuration
REQ-026 SHALL, when IRQ_CTRL_TIMER_EN is defined, have COUNT (32 bits, writable) increment by 1 each cycle, wrapping to 0.
REQ-027 SHALL, with IRQ_CTRL_TIMER_EN defined, set timer pending when COUNT == COMPARE; a COMPARE write clears it, and it is ORed edge-wise into PENDING[TIMER_LINE].
REQ-028 SHALL, when IRQ_CTRL_TIMER_EN is undefined, make COUNT and COMPARE read 0, ignore their writes, and instantiate no timer logic.

Verification
REQ-029 SHALL cover: MASK=8'h08, EDGE=8'h08, pulse irq_in[3] -> interrupt_source=8'h08 at SYNC_STAGES+2 cycles; CLAIM reads 0xB; CLAIM write 3 -> PENDING[3]=0 and interrupt_source=0 next cycle.
REQ-030 SHALL cover: MASK=8'hFF, irq_in[1] and irq_in[6] rise together -> active_id=6; after EOI(6), active_id=1.
REQ-031 SHALL cover: level line 2 held high, EOI(2) -> line 2 re-selected; line 2 low then EOI -> IDLE, PENDING=0.
REQ-032 SHALL cover: CLAIM write 5 while active_id=4 -> no change; MASK[4] cleared -> IDLE with PENDING[4] still 1.
REQ-033 SHALL cover: IRQ_CTRL_TIMER_EN defined, COMPARE=10, COUNT=0, MASK=8'h80 -> interrupt_source=8'h80 about 13 cycles later; COMPARE write clears the timer pending.
REQ-034 SHALL cover: reset asserted while ACTIVE -> interrupt_source=0, all registers at reset values on the next cycle.

Source files
------------

// File: rtl/irq_ctrl.sv
// Eight-line interrupt controller: per-line synchronizers, edge/level pending
// capture, mask, single-level claim/EOI handshake and an optional compare timer
// (enabled with IRQ_CTRL_TIMER_EN).
module irq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMER_LINE  = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq_in,
  input  logic        wr_en,
  input  logic [2:0]  addr,
  input  logic [63:0] wr_data,
  output logic [63:0] rd_data,
  output logic [7:0]  interrupt_source
);

  localparam int unsigned NLINES = 8;
  localparam int unsigned IDW    = 3;
  localparam int unsigned TW     = 32;

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_MASK    = 3'd1;
  localparam logic [2:0] A_EDGE    = 3'd2;
  localparam logic [2:0] A_CLAIM   = 3'd3;
  localparam logic [2:0] A_COUNT   = 3'd4;
  localparam logic [2:0] A_COMPARE = 3'd5;

  logic [SYNC_STAGES-1:0][NLINES-1:0] sync_q;
  logic [NLINES-1:0] s, s_d_q;
  logic [NLINES-1:0] pending_q, pending_d;
  logic [NLINES-1:0] mask_q, edge_q;
  logic [NLINES-1:0] rise, set_evt, clr, req;
  logic [NLINES-1:0] timer_rise, timer_lvl;
  logic [IDW-1:0]    active_id_q, active_id_d, hi_id;
  logic [NLINES-1:0] src_d;
  logic [TW-1:0]     count_rd, compare_rd;
  state_t            state_q, state_d;
  logic              wr_pend, wr_mask, wr_edge, wr_claim, wr_count, wr_compare;
  logic              eoi, mask_drop, active;
  logic              unused_wr_hi;

  assign unused_wr_hi = ^wr_data[63:8];

  assign wr_pend    = wr_en && (addr == A_PENDING);
  assign wr_mask    = wr_en && (addr == A_MASK);
  assign wr_edge    = wr_en && (addr == A_EDGE);
  assign wr_claim   = wr_en && (addr == A_CLAIM);
  assign wr_count   = wr_en && (addr == A_COUNT);
  assign wr_compare = wr_en && (addr == A_COMPARE);

  assign active    = (state_q == ACTIVE);
  assign eoi       = wr_claim && active && (wr_data[2:0] == active_id_q);
  assign mask_drop = wr_mask && active && !wr_data[active_id_q];

  // Synchronizer chain; s is the only version of irq_in used downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      s_d_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      s_d_q  <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

`ifdef IRQ_CTRL_TIMER_EN
  logic [TW-1:0] count_q, compare_q;
  logic          tpend_q, tpend_d_q;

  // Free-running counter; a COMPARE write re-arms the match flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      tpend_q   <= 1'b0;
      tpend_d_q <= 1'b0;
    end else begin
      count_q   <= wr_count ? wr_data[TW-1:0] : count_q + 32'd1;
      if (wr_compare) compare_q <= wr_data[TW-1:0];
      if (wr_compare)                  tpend_q <= 1'b0;
      else if (count_q == compare_q)   tpend_q <= 1'b1;
      tpend_d_q <= tpend_q;
    end
  end

  assign timer_rise = NLINES'(tpend_q & ~tpend_d_q) << TIMER_LINE;
  assign timer_lvl  = NLINES'(tpend_q) << TIMER_LINE;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign timer_rise = '0;
  assign timer_lvl  = '0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  // Edge lines: sticky with set winning over W1C/EOI; level lines track s.
  always_comb begin
    set_evt   = edge_q & (rise | timer_rise);
    clr       = '0;
    if (wr_pend) clr = clr | wr_data[NLINES-1:0];
    if (eoi)     clr = clr | (NLINES'(1) << active_id_q);
    pending_d = (edge_q & ((pending_q & ~clr) | set_evt))
              | (~edge_q & (s | timer_lvl));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (wr_mask) mask_q <= wr_data[NLINES-1:0];
      if (wr_edge) edge_q <= wr_data[NLINES-1:0];
    end
  end

  assign req = pending_q & mask_q;

  // Highest requesting index wins.
  always_comb begin
    hi_id = '0;
    for (int i = 0; i < NLINES; i++) begin
      if (req[i]) hi_id = IDW'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      active_id_q      <= '0;
      interrupt_source <= '0;
    end else begin
      state_q          <= state_d;
      active_id_q      <= active_id_d;
      interrupt_source <= src_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    src_d       = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = ACTIVE;
          active_id_d = hi_id;
        end
      end
      ACTIVE: begin
        if (eoi || mask_drop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ACTIVE) src_d = NLINES'(1) << active_id_d;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      A_PENDING: rd_data = 64'(pending_q);
      A_MASK:    rd_data = 64'(mask_q);
      A_EDGE:    rd_data = 64'(edge_q);
      A_CLAIM:   rd_data = 64'({active, active_id_q});
      A_COUNT:   rd_data = 64'(count_rd);
      A_COMPARE: rd_data = 64'(compare_rd);
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expected values are queued as stimulus is
// applied and retired against register reads and interrupt_source.
module tb_irq_ctrl;

  localparam int unsigned SS = 2;
`ifdef IRQ_CTRL_TIMER_EN
  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF;
`else
  localparam logic [63:0] CMP_RST = 64'h0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_in = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  addr = '0;
  logic [63:0] wr_data = '0;
  logic [63:0] rd_data;
  logic [7:0]  interrupt_source;

  irq_ctrl #(.SYNC_STAGES(SS), .TIMER_LINE(7)) dut (
    .clock(clock),
    .reset(reset),
    .irq_in(irq_in),
    .wr_en(wr_en),
    .addr(addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .interrupt_source(interrupt_source)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];
  int          n;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic score(input logic [63:0] obs);
    string t;
    logic [63:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check_val(t, obs, e);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wr(input logic [2:0] a, input logic [63:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [2:0] a, input string tag, input logic [63:0] exp);
    expect_push(tag, exp);
    addr = a;
    #1;
    score(rd_data);
  endtask

  task automatic src(input string tag, input logic [7:0] exp);
    expect_push(tag, 64'(exp));
    score(64'(interrupt_source));
  endtask

  task automatic wait_src(input string tag, input logic [7:0] exp, input int budget, output int cyc);
    cyc = 0;
    while (interrupt_source !== exp && cyc < budget) begin
      tick();
      cyc++;
    end
    src(tag, exp);
  endtask

  task automatic check_reset(input string p);
    src({p, "_src"}, 8'h00);
    rd(3'd0, {p, "_pending"}, 64'h0);
    rd(3'd1, {p, "_mask"},    64'h0);
    rd(3'd2, {p, "_edge"},    64'h0);
    rd(3'd3, {p, "_claim"},   64'h0);
    rd(3'd4, {p, "_count"},   64'h0);
    rd(3'd5, {p, "_compare"}, CMP_RST);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge clock);
    tick(); tick();
    reset = 1'b0;
    check_reset("rst");

    // Single edge line: latency, claim value, EOI.
    wr(3'd1, 64'h08);
    wr(3'd2, 64'h08);
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    repeat (SS) tick();
    src("t1_pre", 8'h00);
    tick();
    src("t1_latency", 8'h08);
    rd(3'd3, "t1_claim", 64'hB);
    rd(3'd0, "t1_pending", 64'h08);
    wr(3'd3, 64'd3);
    src("t1_eoi_src", 8'h00);
    rd(3'd0, "t1_eoi_pending", 64'h0);

    // Unused addresses.
    wr(3'd6, 64'hFFFF_FFFF);
    rd(3'd6, "addr6", 64'h0);
    rd(3'd7, "addr7", 64'h0);

    // Priority between simultaneous edge arrivals.
    wr(3'd1, 64'hFF);
    wr(3'd2, 64'h42);
    irq_in = 8'h42;
    tick();
    irq_in = 8'h00;
    wait_src("t2_first", 8'h40, 20, n);
    rd(3'd3, "t2_claim6", 64'hE);
    wr(3'd3, 64'd6);
    src("t2_gap", 8'h00);
    tick();
    src("t2_second", 8'h02);
    rd(3'd3, "t2_claim1", 64'h9);
    wr(3'd3, 64'd1);
    src("t2_done", 8'h00);
    rd(3'd0, "t2_pending", 64'h0);

    // Level line held high is re-selected after EOI.
    wr(3'd2, 64'h00);
    irq_in = 8'h04;
    wait_src("t3_sel", 8'h04, 20, n);
    rd(3'd3, "t3_claim", 64'hA);
    wr(3'd3, 64'd2);
    src("t3_idle", 8'h00);
    tick();
    src("t3_resel", 8'h04);
    irq_in = 8'h00;
    repeat (SS + 2) tick();
    rd(3'd0, "t3_pend_low", 64'h0);
    wr(3'd3, 64'd2);
    src("t3_eoi", 8'h00);
    tick();
    src("t3_stay_idle", 8'h00);
    rd(3'd0, "t3_pending", 64'h0);

    // Mismatched EOI ignored; mask drop exits without clearing.
    wr(3'd2, 64'h10);
    wr(3'd1, 64'h10);
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    wait_src("t4_sel", 8'h10, 20, n);
    wr(3'd3, 64'd5);
    src("t4_bad_eoi", 8'h10);
    rd(3'd3, "t4_claim", 64'hC);
    wr(3'd1, 64'h00);
    src("t4_mask_drop", 8'h00);
    rd(3'd3, "t4_claim_idle", 64'h4);
    rd(3'd0, "t4_pending", 64'h10);
    wr(3'd0, 64'h10);
    rd(3'd0, "t4_w1c", 64'h0);

`ifdef IRQ_CTRL_TIMER_EN
    wr(3'd2, 64'h00);
    wr(3'd1, 64'h80);
    wr(3'd5, 64'd10);
    wr(3'd4, 64'd0);
    wait_src("t5_timer", 8'h80, 40, n);
    check_val("t5_latency", 64'(n), 64'd13);
    rd(3'd5, "t5_compare", 64'd10);
    wr(3'd5, 64'hFFFF_FFFF);
    tick();
    rd(3'd0, "t5_tpend_clr", 64'h0);
    wr(3'd3, 64'd7);
    src("t5_eoi", 8'h00);
`else
    wr(3'd4, 64'd123);
    wr(3'd5, 64'd55);
    rd(3'd4, "t5_count_off", 64'h0);
    rd(3'd5, "t5_compare_off", 64'h0);
`endif

    // Reset during service, with a competing write in the same cycle.
    wr(3'd2, 64'h20);
    wr(3'd1, 64'h20);
    irq_in = 8'h20;
    tick();
    irq_in = 8'h00;
    wait_src("t6_sel", 8'h20, 20, n);
    reset = 1'b1;
    addr = 3'd1; wr_data = 64'hFF; wr_en = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0; wr_data = '0;
    check_reset("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
